// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int INSTR_W     = 32;
    localparam int ADDR_W      = 64;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10
    } fetch_state_e;

    // A fetchable pc is word aligned and leaves room for a whole word below the memory end.
    function automatic logic pc_is_legal(input logic [ADDR_W-1:0] pc,
                                         input logic [ADDR_W-1:0] last_pc);
        return (pc[1:0] == 2'b00) && (pc <= last_pc);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Single-entry instruction fetch stage: pc register, one holding slot toward decode,
// halt on an all-zero word and fault on an illegal pc.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_BYTES = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_instr,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [ADDR_W-1:0]   out_pc,
    output logic                halted,
    output logic                fault,
    output logic [31:0]         fetch_count
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(IMEM_BYTES - INSTR_BYTES);

    fetch_state_e        state_r;
    logic [ADDR_W-1:0]   pc_r;
    logic                out_valid_r;
    logic [INSTR_W-1:0]  out_instr_r;
    logic [ADDR_W-1:0]   out_pc_r;
    logic                halted_r;
    logic                fault_r;
    logic [31:0]         fetch_count_r;

    logic                slot_free_s;
    logic                accept_s;
    logic                pc_legal_s;
    logic                instr_zero_s;
    logic [ADDR_W-1:0]   pc_next_s;

    // Slot/handshake qualifiers and the sequential pc candidate.
    always_comb begin
        slot_free_s  = 1'b0;
        accept_s     = 1'b0;
        pc_legal_s   = 1'b0;
        instr_zero_s = 1'b0;
        pc_next_s    = pc_r;
        if (state_r == ST_RUN) begin
            slot_free_s = (~out_valid_r) | out_ready;
            accept_s    = out_valid_r & out_ready;
        end else begin
            slot_free_s = 1'b0;
            accept_s    = 1'b0;
        end
        pc_legal_s   = pc_is_legal(pc_r, LAST_PC);
        instr_zero_s = (imem_instr == 32'h0000_0000);
        // Wraps modulo 2^64; a wrapped pc would already have faulted the range check.
        pc_next_s    = pc_r + 64'd4;
    end

    // Handshake counter, saturating so it never rolls back to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count_r <= 32'h0000_0000;
        end else if (accept_s && (fetch_count_r != 32'hFFFF_FFFF)) begin
            fetch_count_r <= fetch_count_r + 32'd1;
        end
    end

    // Fetch FSM: redirect beats everything, then fault, halt, fetch or stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_RUN;
            pc_r        <= RESET_PC;
            out_valid_r <= 1'b0;
            out_instr_r <= 32'h0000_0000;
            out_pc_r    <= 64'h0;
            halted_r    <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (redirect_valid) begin
                        pc_r        <= redirect_pc;
                        out_valid_r <= 1'b0;
                    end else if (slot_free_s) begin
                        if (!pc_legal_s) begin
                            state_r     <= ST_FAULT;
                            fault_r     <= 1'b1;
                            out_valid_r <= 1'b0;
                        end else if (instr_zero_s) begin
                            state_r     <= ST_HALT;
                            halted_r    <= 1'b1;
                            out_valid_r <= 1'b0;
                        end else begin
                            out_instr_r <= imem_instr;
                            out_pc_r    <= pc_r;
                            out_valid_r <= 1'b1;
                            pc_r        <= pc_next_s;
                        end
                    end
                end
                ST_HALT: begin
                    out_valid_r <= 1'b0;
                    halted_r    <= 1'b1;
                end
                ST_FAULT: begin
                    out_valid_r <= 1'b0;
                    fault_r     <= 1'b1;
                end
                default: begin
                    state_r     <= ST_FAULT;
                    fault_r     <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = pc_r;
    assign out_valid   = out_valid_r;
    assign out_instr   = out_instr_r;
    assign out_pc      = out_pc_r;
    assign halted      = halted_r;
    assign fault       = fault_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with an in-bench instruction memory.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    int applied;
    int miscompares;

    logic [31:0] mem [0:63];

    typedef struct {
        logic        rst;
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        logic        ov;
        logic [63:0] opc;
        logic [31:0] oi;
        logic [63:0] addr;
        logic        hl;
        logic        ft;
        logic [31:0] cnt;
    } vec_t;

    vec_t vq[$];

    fetch_unit #(.RESET_PC(64'h0), .IMEM_BYTES(256)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    assign imem_instr = (imem_addr < 64'd256) ? mem[imem_addr[7:2]] : 32'h0000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic rv, input logic [63:0] rpc, input logic rdy,
                       input logic ov, input logic [63:0] opc, input logic [31:0] oi,
                       input logic [63:0] addr, input logic hl, input logic ft, input logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ov = ov; v.opc = opc; v.oi = oi; v.addr = addr;
        v.hl = hl; v.ft = ft; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic ov, input logic [63:0] opc,
                         input logic [31:0] oi, input logic [63:0] addr, input logic hl,
                         input logic ft, input logic [31:0] cnt);
        applied++;
        if (out_valid !== ov || out_pc !== opc || out_instr !== oi || imem_addr !== addr ||
            halted !== hl || fault !== ft || fetch_count !== cnt) begin
            miscompares++;
            $display("FAIL %s: got v=%b pc=%h instr=%h addr=%h halt=%b fault=%b cnt=%0d, want v=%b pc=%h instr=%h addr=%h halt=%b fault=%b cnt=%0d",
                     name, out_valid, out_pc, out_instr, imem_addr, halted, fault, fetch_count,
                     ov, opc, oi, addr, hl, ft, cnt);
        end
    endtask

    initial begin
        applied        = 0;
        miscompares    = 0;
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        out_ready      = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
        mem[0]  = 32'h0050_0093;
        mem[1]  = 32'h00a0_0113;
        mem[2]  = 32'h0000_0000;
        mem[16] = 32'h0010_0193;
        mem[17] = 32'h0020_0213;

        // straight-line fetch into halt at 0x8, then inputs ignored
        add(1, 0, 64'h0,  1, 1, 64'h0,  32'h0050_0093, 64'h4,   0, 0, 32'd0);
        add(0, 0, 64'h0,  1, 1, 64'h4,  32'h00a0_0113, 64'h8,   0, 0, 32'd1);
        add(0, 0, 64'h0,  1, 0, 64'h4,  32'h00a0_0113, 64'h8,   1, 0, 32'd2);
        add(0, 0, 64'h0,  1, 0, 64'h4,  32'h00a0_0113, 64'h8,   1, 0, 32'd2);
        add(0, 1, 64'h40, 1, 0, 64'h4,  32'h00a0_0113, 64'h8,   1, 0, 32'd2);
        // stall, redirect flush, accept+redirect, top-of-memory boundary into fault
        add(1, 0, 64'h0,  1, 1, 64'h0,  32'h0050_0093, 64'h4,   0, 0, 32'd0);
        add(0, 0, 64'h0,  0, 1, 64'h0,  32'h0050_0093, 64'h4,   0, 0, 32'd0);
        add(0, 0, 64'h0,  0, 1, 64'h0,  32'h0050_0093, 64'h4,   0, 0, 32'd0);
        add(0, 0, 64'h0,  0, 1, 64'h0,  32'h0050_0093, 64'h4,   0, 0, 32'd0);
        add(0, 0, 64'h0,  1, 1, 64'h4,  32'h00a0_0113, 64'h8,   0, 0, 32'd1);
        add(0, 1, 64'h40, 0, 0, 64'h4,  32'h00a0_0113, 64'h40,  0, 0, 32'd1);
        add(0, 0, 64'h0,  0, 1, 64'h40, 32'h0010_0193, 64'h44,  0, 0, 32'd1);
        add(0, 0, 64'h0,  1, 1, 64'h44, 32'h0020_0213, 64'h48,  0, 0, 32'd2);
        add(0, 1, 64'hFC, 1, 0, 64'h44, 32'h0020_0213, 64'hFC,  0, 0, 32'd3);
        add(0, 0, 64'h0,  1, 1, 64'hFC, 32'h03F0_0013, 64'h100, 0, 0, 32'd3);
        add(0, 0, 64'h0,  1, 0, 64'hFC, 32'h03F0_0013, 64'h100, 0, 1, 32'd4);
        add(0, 1, 64'h0,  1, 0, 64'hFC, 32'h03F0_0013, 64'h100, 0, 1, 32'd4);
        // out-of-range and misaligned redirect targets
        add(1, 1, 64'h102, 1, 0, 64'h0, 32'h0, 64'h102, 0, 0, 32'd0);
        add(0, 0, 64'h0,   1, 0, 64'h0, 32'h0, 64'h102, 0, 1, 32'd0);
        add(1, 1, 64'hFD,  1, 0, 64'h0, 32'h0, 64'hFD,  0, 0, 32'd0);
        add(0, 0, 64'h0,   1, 0, 64'h0, 32'h0, 64'hFD,  0, 1, 32'd0);

        foreach (vq[k]) begin
            @(negedge clk);
            if (vq[k].rst) begin
                reset_n = 1'b0;
                #1;
                reset_n = 1'b1;
            end
            redirect_valid = vq[k].rv;
            redirect_pc    = vq[k].rpc;
            out_ready      = vq[k].rdy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", k), vq[k].ov, vq[k].opc, vq[k].oi, vq[k].addr,
                  vq[k].hl, vq[k].ft, vq[k].cnt);
        end

        // reset asserted mid-stall takes effect without a clock edge
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        reset_n        = 1'b1;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        @(posedge clk);
        #1;
        check("ms_fetch", 1'b1, 64'h0, 32'h0050_0093, 64'h4, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("ms_stall", 1'b1, 64'h0, 32'h0050_0093, 64'h4, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("ms_async", 1'b0, 64'h0, 32'h0, 64'h0, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        check("ms_held", 1'b0, 64'h0, 32'h0, 64'h0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ms_first", 1'b1, 64'h0, 32'h0050_0093, 64'h4, 1'b0, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
